// File: rtl/ising_axil_bridge_pkg.sv
// Shared response codes, FSM encodings and the address-window helper for the Ising AXI4-Lite bridge.
package ising_axil_bridge_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_RESP  = 2'd2
  } wr_state_e;

  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ising_axil_hold.sv
// Single-entry valid+data holding register; ready is simply "not full".
module ising_axil_hold #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         clr_i,
  output logic         ready_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Capture once when empty; only an explicit clear empties the entry again.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= {W{1'b0}};
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ising_axil_bridge.sv
// AXI4-Lite slave front-end for the Ising register wrapper; independent read and write FSMs.
// Optional address window checking is enabled by defining ISING_AXIL_ADDR_CHECK_EN.
module ising_axil_bridge
  import ising_axil_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI        = 32'h0000_0FFC
) (
  input  logic        clk,
  input  logic        axi_rst,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        core_arvalid,
  output logic [31:0] core_araddr,
  input  logic        core_rvalid,
  input  logic        core_rresp,
  input  logic [31:0] core_rdata,
  output logic        core_rready,
  output logic        core_wready,
  output logic [31:0] core_wr_addr,
  output logic [31:0] core_wdata
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);

  rd_state_e     rd_q;
  logic [CW-1:0] tmo_q;
  logic          arready_q, core_arvalid_q, core_rready_q, rvalid_q;
  logic [31:0]   araddr_q, rdata_q;
  logic [1:0]    rresp_q;

  // Read path: AR capture, one-cycle core strobe, bounded wait, R response.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      rd_q           <= R_IDLE;
      tmo_q          <= {CW{1'b0}};
      arready_q      <= 1'b1;
      core_arvalid_q <= 1'b0;
      core_rready_q  <= 1'b0;
      rvalid_q       <= 1'b0;
      araddr_q       <= 32'h0;
      rdata_q        <= 32'h0;
      rresp_q        <= AXI_RESP_OKAY;
    end else begin
      case (rd_q)
        R_IDLE: begin
          if (s_arvalid) begin
            arready_q <= 1'b0;
            araddr_q  <= s_araddr;
`ifdef ISING_AXIL_ADDR_CHECK_EN
            if (!addr_in_window(s_araddr, ADDR_LO, ADDR_HI)) begin
              rdata_q  <= 32'h0;
              rresp_q  <= AXI_RESP_SLVERR;
              rvalid_q <= 1'b1;
              rd_q     <= R_RESP;
            end else
`endif
            begin
              core_arvalid_q <= 1'b1;
              rd_q           <= R_REQ;
            end
          end
        end
        R_REQ: begin
          core_arvalid_q <= 1'b0;
          core_rready_q  <= 1'b1;
          tmo_q          <= {CW{1'b0}};
          rd_q           <= R_WAIT;
        end
        R_WAIT: begin
          // A late answer in the final wait cycle still wins over the timeout.
          if (core_rvalid) begin
            core_rready_q <= 1'b0;
            rdata_q       <= core_rdata;
            rresp_q       <= {core_rresp, 1'b0};
            rvalid_q      <= 1'b1;
            rd_q          <= R_RESP;
          end else if (tmo_q >= TMO_LAST) begin
            core_rready_q <= 1'b0;
            rdata_q       <= 32'h0;
            rresp_q       <= AXI_RESP_SLVERR;
            rvalid_q      <= 1'b1;
            rd_q          <= R_RESP;
          end else if (tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + CW'(1);
          end
        end
        R_RESP: begin
          if (s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_q      <= R_IDLE;
          end
        end
        default: rd_q <= R_IDLE;
      endcase
    end
  end

  wr_state_e   wr_q;
  logic        core_wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic        aw_full_s, w_full_s, hold_clr_s;
  logic [31:0] aw_addr_s, w_data_s;

  assign hold_clr_s = (wr_q == W_RESP) && s_bready;

  ising_axil_hold #(.W(32)) u_aw_hold (
    .clk(clk), .rst_i(axi_rst), .valid_i(s_awvalid), .data_i(s_awaddr), .clr_i(hold_clr_s),
    .ready_o(s_awready), .full_o(aw_full_s), .data_o(aw_addr_s)
  );

  ising_axil_hold #(.W(32)) u_w_hold (
    .clk(clk), .rst_i(axi_rst), .valid_i(s_wvalid), .data_i(s_wdata), .clr_i(hold_clr_s),
    .ready_o(s_wready), .full_o(w_full_s), .data_o(w_data_s)
  );

  // Write path: both holds full -> one core strobe -> B response; holds free only after B.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      wr_q          <= W_IDLE;
      core_wready_q <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= AXI_RESP_OKAY;
    end else begin
      case (wr_q)
        W_IDLE: begin
          if (aw_full_s && w_full_s) begin
`ifdef ISING_AXIL_ADDR_CHECK_EN
            if (!addr_in_window(aw_addr_s, ADDR_LO, ADDR_HI)) begin
              bvalid_q <= 1'b1;
              bresp_q  <= AXI_RESP_SLVERR;
              wr_q     <= W_RESP;
            end else
`endif
            begin
              core_wready_q <= 1'b1;
              wr_q          <= W_ISSUE;
            end
          end
        end
        W_ISSUE: begin
          core_wready_q <= 1'b0;
          bvalid_q      <= 1'b1;
          bresp_q       <= AXI_RESP_OKAY;
          wr_q          <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q <= 1'b0;
            wr_q     <= W_IDLE;
          end
        end
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  assign s_arready    = arready_q;
  assign core_arvalid = core_arvalid_q;
  assign core_araddr  = araddr_q;
  assign core_rready  = core_rready_q;
  assign s_rvalid     = rvalid_q;
  assign s_rdata      = rdata_q;
  assign s_rresp      = rresp_q;
  assign core_wready  = core_wready_q;
  assign core_wr_addr = aw_addr_s;
  assign core_wdata   = w_data_s;
  assign s_bvalid     = bvalid_q;
  assign s_bresp      = bresp_q;

  // Byte strobes are deliberately ignored: every write is a full word.
  logic unused_s;
`ifdef ISING_AXIL_ADDR_CHECK_EN
  assign unused_s = ^s_wstrb;
`else
  assign unused_s = ^{s_wstrb, ADDR_LO, ADDR_HI};
`endif

endmodule

// File: tb/tb_ising_axil_bridge.sv
// Scoreboard bench for ising_axil_bridge: directed timing/reset cases plus randomized read/write traffic.
`timescale 1ns/1ps
module tb_ising_axil_bridge;
  import ising_axil_bridge_pkg::*;

  localparam int          TMO          = 1024;
  localparam logic [31:0] ADDR_HI      = 32'h0000_0FFC;
  localparam logic [31:0] CTR_MAX_ADDR = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        axi_rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        core_arvalid, core_rvalid, core_rresp, core_rready, core_wready;
  logic [31:0] core_araddr, core_rdata, core_wr_addr, core_wdata;

  always #5 clk = ~clk;

  ising_axil_bridge dut (
    .clk(clk), .axi_rst(axi_rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .core_arvalid(core_arvalid), .core_araddr(core_araddr), .core_rvalid(core_rvalid),
    .core_rresp(core_rresp), .core_rdata(core_rdata), .core_rready(core_rready),
    .core_wready(core_wready), .core_wr_addr(core_wr_addr), .core_wdata(core_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ar_cnt  = 0;
  int w_cnt   = 0;

  logic [63:0] exp_w[$];
  logic [31:0] exp_ar[$];
  logic [33:0] exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] wmem [0:1023];

  bit rsp_never = 1'b0;
  bit rsp_err   = 1'b0;
  int rsp_delay = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic bit legal(input logic [31:0] a);
`ifdef ISING_AXIL_ADDR_CHECK_EN
    return (a <= ADDR_HI) && (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Monitor: scoreboard pops on DUT outputs, plus R-channel stability while stalled.
  initial begin
    logic        pv, phs;
    logic [33:0] pr;
    pv = 1'b0; phs = 1'b0; pr = 34'h0;
    forever begin
      @(negedge clk);
      if (axi_rst) begin
        pv = 1'b0;
        phs = 1'b0;
      end else begin
        if (core_wready) begin
          w_cnt++;
          if (exp_w.size() == 0) fail_now("unexpected_core_wready");
          else check("core_write", {core_wr_addr, core_wdata}, exp_w.pop_front());
          wmem[core_wr_addr[11:2]] = core_wdata;
        end
        if (core_arvalid) begin
          ar_cnt++;
          if (exp_ar.size() == 0) fail_now("unexpected_core_arvalid");
          else check("core_araddr", core_araddr, exp_ar.pop_front());
        end
        if (pv && !phs) check("r_hold_stable", {s_rvalid, s_rdata, s_rresp}, {1'b1, pr});
        if (s_rvalid && s_rready) begin
          if (exp_r.size() == 0) fail_now("unexpected_r_beat");
          else check("r_resp", {s_rdata, s_rresp}, exp_r.pop_front());
        end
        if (s_bvalid && s_bready) begin
          if (exp_b.size() == 0) fail_now("unexpected_b_beat");
          else check("bresp", s_bresp, exp_b.pop_front());
        end
        pv  = s_rvalid;
        pr  = {s_rdata, s_rresp};
        phs = s_rready;
      end
    end
  end

  // Wrapper model: answers each read strobe after rsp_delay cycles from its word memory.
  initial begin
    logic [31:0] a;
    core_rvalid = 1'b0; core_rdata = 32'h0; core_rresp = 1'b0;
    forever begin
      @(negedge clk);
      if (core_arvalid && !axi_rst && !rsp_never) begin
        a = core_araddr;
        repeat (rsp_delay) @(posedge clk);
        #1;
        core_rvalid = 1'b1; core_rdata = wmem[a[11:2]]; core_rresp = rsp_err;
        for (int k = 0; k < 64; k++) begin
          @(negedge clk);
          if (core_rready) break;
        end
        @(posedge clk); #1;
        core_rvalid = 1'b0; core_rdata = 32'h0; core_rresp = 1'b0;
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input int d);
    bit ok = 1'b0;
    repeat (d) begin @(posedge clk); #1; end
    s_awvalid = 1'b1; s_awaddr = a;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = s_awready; end
    if (!ok) fail_now("aw_handshake_timeout");
    @(posedge clk); #1 s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] dt, input int d);
    bit ok = 1'b0;
    repeat (d) begin @(posedge clk); #1; end
    s_wvalid = 1'b1; s_wdata = dt; s_wstrb = 4'($urandom_range(0, 15));
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = s_wready; end
    if (!ok) fail_now("w_handshake_timeout");
    @(posedge clk); #1 s_wvalid = 1'b0;
  endtask

  task automatic wait_bvalid();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = s_bvalid; end
    if (!ok) fail_now("bvalid_timeout");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] dt,
                          input int da, input int dw, input int bd);
    if (legal(a)) begin
      exp_w.push_back({a, dt});
      exp_b.push_back(AXI_RESP_OKAY);
      ref_mem[a] = dt;
    end else begin
      exp_b.push_back(AXI_RESP_SLVERR);
    end
    fork
      send_aw(a, da);
      send_w(dt, dw);
    join
    wait_bvalid();
    repeat (bd) begin @(posedge clk); #1; end
    @(posedge clk); #1 s_bready = 1'b1;
    @(posedge clk); #1 s_bready = 1'b0;
  endtask

  task automatic issue_ar(input logic [31:0] a, output int hs);
    bit ok = 1'b0;
    s_arvalid = 1'b1; s_araddr = a;
    for (int k = 0; k < 200 && !ok; k++) begin @(negedge clk); ok = s_arready; end
    if (!ok) fail_now("ar_handshake_timeout");
    hs = cyc;
    @(posedge clk); #1 s_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rd, output int lat);
    int hs;
    bit ok = 1'b0;
    if (!legal(a))      exp_r.push_back({32'h0, AXI_RESP_SLVERR});
    else if (rsp_never) exp_r.push_back({32'h0, AXI_RESP_SLVERR});
    else                exp_r.push_back({ref_rd(a), rsp_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY});
    if (legal(a)) exp_ar.push_back(a);
    issue_ar(a, hs);
    for (int k = 0; k < TMO + 100 && !ok; k++) begin @(negedge clk); ok = s_rvalid; end
    if (!ok) fail_now("rvalid_timeout");
    lat = cyc - hs;
    repeat (rd) begin @(posedge clk); #1; end
    @(posedge clk); #1 s_rready = 1'b1;
    @(posedge clk); #1 s_rready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check(name, {s_awready, s_wready, s_arready, s_rvalid, s_bvalid,
                 core_arvalid, core_wready, core_rready}, 8'b1110_0000);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 axi_rst = 1'b1;
    @(posedge clk); #1 axi_rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, ar0, w0;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) wmem[i] = 32'h0;
    axi_rst = 1'b1;
    s_awvalid = 1'b0; s_awaddr = 32'h0; s_wvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0;
    s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = 32'h0; s_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_handshake_state");
    check("reset_data_regs", {s_rdata, s_rresp, s_bresp, core_araddr}, 68'h0);
    @(posedge clk); #1 axi_rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset_release");

    // AW first, W three cycles later; a second AW must be refused while B is pending.
    @(posedge clk); #1;
    exp_w.push_back({CTR_MAX_ADDR, 32'd500});
    exp_b.push_back(AXI_RESP_OKAY);
    ref_mem[CTR_MAX_ADDR] = 32'd500;
    fork
      send_aw(CTR_MAX_ADDR, 0);
      send_w(32'd500, 3);
    join
    wait_bvalid();
    @(posedge clk); #1 s_awvalid = 1'b1; s_awaddr = 32'h0000_0020;
    repeat (3) begin
      @(negedge clk);
      check("aw_refused_while_b_pending", {s_awready, s_bvalid}, 2'b01);
    end
    @(posedge clk); #1 s_awvalid = 1'b0; s_bready = 1'b1;
    @(posedge clk); #1 s_bready = 1'b0;
    @(negedge clk);
    check("aw_w_ready_after_b", {s_awready, s_wready, s_bvalid}, 3'b110);

    // Read with the wrapper answering on the following cycle; master stalls 5 cycles.
    @(posedge clk); #1;
    rsp_delay = 1;
    do_read(CTR_MAX_ADDR, 4, lat);
    check("read_latency_3", lat, 3);

    // AW, W and AR all presented in the same cycle.
    @(posedge clk); #1;
    ar0 = ar_cnt; w0 = w_cnt;
    fork
      do_write(32'h0000_0040, 32'hCAFE_0001, 0, 0, 1);
      do_read(CTR_MAX_ADDR, 0, lat);
    join
    check("simultaneous_strobes", {32'(ar_cnt - ar0), 32'(w_cnt - w0)}, {32'd1, 32'd1});

    // Wrapper never answers.
    @(posedge clk); #1;
    rsp_never = 1'b1;
    do_read(32'h0000_0044, 0, lat);
    check("timeout_latency", lat, TMO + 2);

    // Reset while waiting on the wrapper.
    @(posedge clk); #1;
    exp_ar.push_back(32'h0000_0048);
    issue_ar(32'h0000_0048, lat);
    repeat (5) @(posedge clk);
    pulse_reset();
    check_idle("reset_in_r_wait");
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_idle("idle_after_r_wait_reset");
    rsp_never = 1'b0;

    // Reset while the B response is pending.
    @(posedge clk); #1;
    exp_w.push_back({32'h0000_004C, 32'h1234_5678});
    ref_mem[32'h0000_004C] = 32'h1234_5678;
    fork
      send_aw(32'h0000_004C, 1);
      send_w(32'h1234_5678, 0);
    join
    wait_bvalid();
    pulse_reset();
    check_idle("reset_in_w_resp");
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_idle("idle_after_w_resp_reset");

`ifdef ISING_AXIL_ADDR_CHECK_EN
    @(posedge clk); #1;
    do_write(ADDR_HI + 32'd4, 32'hDEAD_BEEF, 0, 1, 0);
    do_read(ADDR_HI + 32'd4, 1, lat);
    check("rejected_read_latency", lat, 1);
`endif

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1023)) << 2;
      else a = 32'h0000_0100 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        rsp_delay = $urandom_range(1, 4);
        rsp_err   = ($urandom_range(0, 3) == 0);
        do_read(a, $urandom_range(0, 3), lat);
        check("rand_read_latency", lat, rsp_delay + 2);
        rsp_err = 1'b0;
      end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", {16'(exp_w.size()), 16'(exp_ar.size()),
                                 16'(exp_r.size()), 16'(exp_b.size())}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
